// File: rtl/ramdisk_defs.sv
`default_nettype none
// ============================================================================
//  Module   : ramdisk_defs (package)
//  Purpose  : Shared definitions for the RAM-disk block sequencer: block size,
//             sequencer state encodings and RAM-disk handshake levels.
//  Revision : 1.0 - initial release
// ============================================================================
package ramdisk_defs;

    // Words per RAM-disk block
    localparam int c_BLOCK_SIZE = 256;

    // Width of the shared watchdog down-counter
    localparam int c_WD_WIDTH = 16;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GATE      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    // RAM-disk handshake levels: rd_command_ready is high when the disk is idle
    localparam logic c_RD_READY = 1'b1;
    localparam logic c_RD_BUSY  = 1'b0;
    localparam logic c_CMD_ON   = 1'b1;
    localparam logic c_CMD_OFF  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/xfer_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : xfer_watchdog
//  Purpose  : Loadable down-counting watchdog. After a load with limit L the
//             expired flag rises once L further cycles have elapsed, and stays
//             up until the counter is stopped or reloaded.
//  Revision : 1.0 - initial release
// ============================================================================
module xfer_watchdog #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,      // synchronous, active-low
    input  logic             i_load,
    input  logic             i_stop,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_expired
);

    logic             r_armed;
    logic [WIDTH-1:0] r_remain;

    // Count down while armed; load has priority over stop
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_armed  <= 1'b0;
            r_remain <= '0;
        end else if (i_load) begin
            r_armed  <= 1'b1;
            r_remain <= i_limit;
        end else if (i_stop) begin
            r_armed  <= 1'b0;
        end else if (r_armed && (r_remain != '0)) begin
            r_remain <= r_remain - 1'b1;
        end
    end

    assign o_expired = r_armed && (r_remain == '0);

endmodule
`default_nettype wire

// File: rtl/ramdisk_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ramdisk_sequencer
//  Purpose  : Sequences multi-block read/write transfers to a RAM disk, one
//             block command at a time, gated on FIFO space and guarded by
//             acknowledge and block-completion timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
module ramdisk_sequencer
    import ramdisk_defs::*;
#(
    parameter int BLOCKS      = 120,
    parameter int BLOCK_SIZE  = c_BLOCK_SIZE,
    parameter int ACK_TIMEOUT = 8,
    parameter int BLK_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op_write,
    input  logic [31:0] start_block,
    input  logic [15:0] block_count,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        aborted,
    output logic [15:0] blocks_left,
    input  logic        rd_command_ready,
    output logic        rd_read_cmd,
    output logic        rd_write_cmd,
    output logic [31:0] rd_block_address,
    input  logic [9:0]  wfifo_level,
    input  logic [9:0]  rfifo_free
);

    // Watchdog limits are loaded as N-1 so the timeout fires after N cycles
    localparam logic [c_WD_WIDTH-1:0] c_ACK_LIMIT = c_WD_WIDTH'(ACK_TIMEOUT - 1);
    localparam logic [c_WD_WIDTH-1:0] c_BLK_LIMIT = c_WD_WIDTH'(BLK_TIMEOUT - 1);
    localparam logic [31:0]           c_BLK_WORDS = 32'(BLOCK_SIZE);
    localparam logic [32:0]           c_BLOCKS_33 = 33'(BLOCKS);

    state_t      r_state,    w_state_nxt;
    logic        r_op_write, w_op_write_nxt;
    logic [31:0] r_block,    w_block_nxt;
    logic [15:0] r_left,     w_left_nxt;
    logic        r_busy,     w_busy_nxt;
    logic        r_done,     w_done_nxt;
    logic        r_error,    w_error_nxt;
    logic        r_aborted,  w_aborted_nxt;
    logic        r_rd_cmd,   w_rd_cmd_nxt;
    logic        r_wr_cmd,   w_wr_cmd_nxt;
    logic        r_pend,     w_pend_nxt;

    logic                  w_wd_load;
    logic                  w_wd_stop;
    logic [c_WD_WIDTH-1:0] w_wd_limit;
    logic                  w_wd_expired;
    logic                  w_fifo_ok;
    logic                  w_abort_now;
    logic [32:0]           w_range_end;

    // Range end computed one bit wider so a large start_block cannot wrap
    assign w_range_end = {1'b0, start_block} + {17'd0, block_count};
    assign w_fifo_ok   = r_op_write ? ({22'd0, wfifo_level} >= c_BLK_WORDS)
                                    : ({22'd0, rfifo_free}  >= c_BLK_WORDS);
    assign w_abort_now = r_pend | abort;

    xfer_watchdog #(
        .WIDTH     (c_WD_WIDTH)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_wd_load),
        .i_stop    (w_wd_stop),
        .i_limit   (w_wd_limit),
        .o_expired (w_wd_expired)
    );

    // Next-state and next-output decode for the transfer sequencer
    always_comb begin
        w_state_nxt    = r_state;
        w_op_write_nxt = r_op_write;
        w_block_nxt    = r_block;
        w_left_nxt     = r_left;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_error_nxt    = r_error;
        w_aborted_nxt  = r_aborted;
        w_rd_cmd_nxt   = r_rd_cmd;
        w_wr_cmd_nxt   = r_wr_cmd;
        w_pend_nxt     = r_pend;
        w_wd_load      = 1'b0;
        w_wd_stop      = 1'b0;
        w_wd_limit     = c_ACK_LIMIT;

        // An abort anywhere in a transfer is remembered until the next start
        if ((r_state != ST_IDLE) && abort) begin
            w_pend_nxt = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_op_write_nxt = op_write;
                    w_block_nxt    = start_block;
                    w_left_nxt     = block_count;
                    w_busy_nxt     = 1'b1;
                    w_error_nxt    = 1'b0;
                    w_aborted_nxt  = 1'b0;
                    w_pend_nxt     = 1'b0;
                    if (block_count == 16'd0) begin
                        w_state_nxt = ST_FINISH;
                    end else if (w_range_end > c_BLOCKS_33) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_state_nxt = ST_GATE;
                    end
                end
            end
            ST_GATE: begin
                if (w_abort_now) begin
                    w_aborted_nxt = 1'b1;
                    w_state_nxt   = ST_FINISH;
                end else if (w_fifo_ok) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_rd_cmd_nxt = r_op_write ? c_CMD_OFF : c_CMD_ON;
                w_wr_cmd_nxt = r_op_write ? c_CMD_ON  : c_CMD_OFF;
                w_wd_load    = 1'b1;
                w_wd_limit   = c_ACK_LIMIT;
                w_state_nxt  = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (rd_command_ready == c_RD_BUSY) begin
                    // Disk took the command: release it and time the block
                    w_rd_cmd_nxt = c_CMD_OFF;
                    w_wr_cmd_nxt = c_CMD_OFF;
                    w_wd_load    = 1'b1;
                    w_wd_limit   = c_BLK_LIMIT;
                    w_state_nxt  = ST_WAIT_DONE;
                end else if (w_wd_expired) begin
                    w_rd_cmd_nxt = c_CMD_OFF;
                    w_wr_cmd_nxt = c_CMD_OFF;
                    w_error_nxt  = 1'b1;
                    w_wd_stop    = 1'b1;
                    w_state_nxt  = ST_FINISH;
                end
            end
            ST_WAIT_DONE: begin
                if (rd_command_ready == c_RD_READY) begin
                    w_left_nxt  = r_left - 16'd1;
                    w_block_nxt = r_block + 32'd1;
                    w_wd_stop   = 1'b1;
                    if (r_left == 16'd1) begin
                        w_state_nxt = ST_FINISH;
                    end else if (w_abort_now) begin
                        w_aborted_nxt = 1'b1;
                        w_state_nxt   = ST_FINISH;
                    end else begin
                        w_state_nxt = ST_GATE;
                    end
                end else if (w_wd_expired) begin
                    w_error_nxt = 1'b1;
                    w_wd_stop   = 1'b1;
                    w_state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_rd_cmd_nxt = c_CMD_OFF;
                w_wr_cmd_nxt = c_CMD_OFF;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_op_write <= 1'b0;
            r_block    <= 32'd0;
            r_left     <= 16'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_aborted  <= 1'b0;
            r_rd_cmd   <= c_CMD_OFF;
            r_wr_cmd   <= c_CMD_OFF;
            r_pend     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_op_write <= w_op_write_nxt;
            r_block    <= w_block_nxt;
            r_left     <= w_left_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            r_aborted  <= w_aborted_nxt;
            r_rd_cmd   <= w_rd_cmd_nxt;
            r_wr_cmd   <= w_wr_cmd_nxt;
            r_pend     <= w_pend_nxt;
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign error            = r_error;
    assign aborted          = r_aborted;
    assign blocks_left      = r_left;
    assign rd_read_cmd      = r_rd_cmd;
    assign rd_write_cmd     = r_wr_cmd;
    assign rd_block_address = r_block;

endmodule
`default_nettype wire

// File: tb/tb_ramdisk_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ramdisk_sequencer
//  Purpose  : Directed self-checking bench for ramdisk_sequencer with a
//             behavioural RAM-disk handshake model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ramdisk_sequencer;

    localparam int c_BUSY_CYC = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op_write = 1'b0;
    logic [31:0] start_block = 32'd0;
    logic [15:0] block_count = 16'd0;
    logic        abort = 1'b0;
    logic        busy, done, error, aborted;
    logic [15:0] blocks_left;
    logic        rd_command_ready = 1'b1;
    logic        rd_read_cmd, rd_write_cmd;
    logic [31:0] rd_block_address;
    logic [9:0]  wfifo_level = 10'd0;
    logic [9:0]  rfifo_free = 10'd0;

    int n_tests = 0;
    int n_fail  = 0;

    // RAM-disk model state and command log
    logic        m_stuck = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_prev = 1'b0;
    int          m_cnt = 0;
    int          cmd_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] log_addr [64];
    logic        log_wr   [64];

    ramdisk_sequencer #(
        .BLOCKS      (120),
        .BLOCK_SIZE  (256),
        .ACK_TIMEOUT (8),
        .BLK_TIMEOUT (1024)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .op_write         (op_write),
        .start_block      (start_block),
        .block_count      (block_count),
        .abort            (abort),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .aborted          (aborted),
        .blocks_left      (blocks_left),
        .rd_command_ready (rd_command_ready),
        .rd_read_cmd      (rd_read_cmd),
        .rd_write_cmd     (rd_write_cmd),
        .rd_block_address (rd_block_address),
        .wfifo_level      (wfifo_level),
        .rfifo_free       (rfifo_free)
    );

    always #5 clk = ~clk;

    // RAM-disk model: evaluated on the falling edge, away from the DUT's edge
    always @(negedge clk) begin
        if (!reset) begin
            rd_command_ready = 1'b1;
            m_busy = 1'b0;
            m_prev = 1'b0;
            m_cnt  = 0;
        end else begin
            if ((rd_read_cmd || rd_write_cmd) && !m_prev) begin
                if (cmd_cnt < 64) begin
                    log_addr[cmd_cnt] = rd_block_address;
                    log_wr[cmd_cnt]   = rd_write_cmd;
                end
                cmd_cnt = cmd_cnt + 1;
            end
            if (m_busy) begin
                if (m_cnt == 0) begin
                    rd_command_ready = 1'b1;
                    m_busy = 1'b0;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end else if ((rd_read_cmd || rd_write_cmd) && !m_stuck) begin
                rd_command_ready = 1'b0;
                m_busy = 1'b1;
                m_cnt  = c_BUSY_CYC;
            end
            m_prev = rd_read_cmd || rd_write_cmd;
            if (done) done_cnt = done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic wr, input logic [31:0] sb, input logic [15:0] cnt);
        start       = 1'b1;
        op_write    = wr;
        start_block = sb;
        block_count = cnt;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int cyc;
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        check(tag, 64'(cyc > 0), 64'd1);
    endtask

    task automatic wait_cmds(input string tag, input int base, input int n, input int max);
        int ok;
        ok = 0;
        for (int i = 0; i < max; i++) begin
            if (cmd_cnt - base >= n) begin
                ok = 1;
                break;
            end
            tick();
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    initial begin
        int base, d0, cyc;

        // Reset state
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done_err_abt", 64'({done, error, aborted}), 64'd0);
        check("rst_cmds", 64'({rd_read_cmd, rd_write_cmd}), 64'd0);
        check("rst_left", 64'(blocks_left), 64'd0);
        check("rst_addr", 64'(rd_block_address), 64'd0);
        reset = 1'b1;
        tick();

        // Write 3 blocks from block 2, with an ignored start mid-transfer
        wfifo_level = 10'd512;
        base = cmd_cnt;
        d0   = done_cnt;
        do_start(1'b1, 32'd2, 16'd3);
        check("wr_busy", 64'(busy), 64'd1);
        check("wr_left_latched", 64'(blocks_left), 64'd3);
        wait_cmds("wr_first_cmd", base, 1, 50);
        do_start(1'b0, 32'd50, 16'd1);
        wait_done("wr_done", 200);
        tick();
        check("wr_busy_clear", 64'(busy), 64'd0);
        repeat (3) tick();
        check("wr_done_once", 64'(done_cnt - d0), 64'd1);
        check("wr_cmd_count", 64'(cmd_cnt - base), 64'd3);
        check("wr_addr0", 64'(log_addr[base]), 64'd2);
        check("wr_addr1", 64'(log_addr[base + 1]), 64'd3);
        check("wr_addr2", 64'(log_addr[base + 2]), 64'd4);
        check("wr_kinds", 64'({log_wr[base], log_wr[base + 1], log_wr[base + 2]}), 64'h7);
        check("wr_left_end", 64'(blocks_left), 64'd0);
        check("wr_error", 64'(error), 64'd0);

        // Read 1 block gated on read-FIFO space
        rfifo_free = 10'd100;
        base = cmd_cnt;
        do_start(1'b0, 32'd7, 16'd1);
        repeat (20) tick();
        check("rd_gated_nocmd", 64'(cmd_cnt - base), 64'd0);
        check("rd_gated_busy", 64'(busy), 64'd1);
        rfifo_free = 10'd256;
        cyc = -1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (rd_read_cmd === 1'b1) begin
                cyc = i;
                break;
            end
        end
        check("rd_cmd_latency", 64'(cyc), 64'd2);
        check("rd_no_wr_cmd", 64'(rd_write_cmd), 64'd0);
        wait_done("rd_done", 100);
        check("rd_addr", 64'(log_addr[base]), 64'd7);
        check("rd_kind", 64'(log_wr[base]), 64'd0);
        check("rd_error", 64'(error), 64'd0);

        // Out-of-range request: 118 + 3 > 120
        base = cmd_cnt;
        do_start(1'b0, 32'd118, 16'd3);
        tick();
        check("range_done", 64'(done), 64'd1);
        check("range_error", 64'(error), 64'd1);
        check("range_busy", 64'(busy), 64'd0);
        tick();
        check("range_done_pulse", 64'(done), 64'd0);
        check("range_nocmd", 64'(cmd_cnt - base), 64'd0);

        // Zero-length request finishes cleanly and clears the previous error
        do_start(1'b1, 32'd5, 16'd0);
        tick();
        check("zero_done", 64'(done), 64'd1);
        check("zero_error", 64'(error), 64'd0);

        // Abort during the second block of a 5-block read
        base = cmd_cnt;
        do_start(1'b0, 32'd10, 16'd5);
        wait_cmds("abt_second_cmd", base, 2, 100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("abt_done", 100);
        check("abt_aborted", 64'(aborted), 64'd1);
        check("abt_left", 64'(blocks_left), 64'd3);
        check("abt_cmd_count", 64'(cmd_cnt - base), 64'd2);
        check("abt_addr1", 64'(log_addr[base + 1]), 64'd11);
        check("abt_error", 64'(error), 64'd0);

        // Disk never acknowledges: ACK timeout after 8 cycles
        m_stuck = 1'b1;
        do_start(1'b1, 32'd0, 16'd2);
        cyc = -1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (rd_write_cmd === 1'b1) begin
                cyc = i;
                break;
            end
        end
        check("to_cmd_seen", 64'(cyc > 0), 64'd1);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (error === 1'b1) begin
                cyc = i;
                break;
            end
        end
        check("to_error_cycles", 64'(cyc), 64'd8);
        check("to_cmd_dropped", 64'(rd_write_cmd), 64'd0);
        tick();
        check("to_done", 64'(done), 64'd1);
        m_stuck = 1'b0;
        repeat (2) tick();

        // Reset in the middle of WAIT_DONE, then a normal transfer
        base = cmd_cnt;
        do_start(1'b1, 32'd1, 16'd3);
        for (int i = 0; i < 10 && rd_write_cmd !== 1'b1; i++) tick();
        for (int i = 0; i < 10 && rd_write_cmd !== 1'b0; i++) tick();
        check("mr_in_wait_done", 64'({busy, rd_write_cmd}), 64'h2);
        reset = 1'b0;
        tick();
        check("mr_busy_cmds", 64'({busy, rd_read_cmd, rd_write_cmd}), 64'd0);
        check("mr_flags", 64'({done, error, aborted}), 64'd0);
        check("mr_left_addr", 64'({blocks_left, rd_block_address}), 64'd0);
        reset = 1'b1;
        repeat (2) tick();
        base = cmd_cnt;
        do_start(1'b1, 32'd20, 16'd2);
        wait_done("mr_after_done", 200);
        check("mr_after_cmds", 64'(cmd_cnt - base), 64'd2);
        check("mr_after_addr1", 64'(log_addr[base + 1]), 64'd21);
        check("mr_after_left", 64'(blocks_left), 64'd0);
        check("mr_after_error", 64'(error), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute bound on simulation time
    initial begin
        #500000;
        $display("FAIL global_timeout: got no summary expected finish");
        $fatal(1, "simulation time bound exceeded");
    end

endmodule
`default_nettype wire

// File: doc/ramdisk_sequencer.md
RAMDISK_SEQUENCER -- requirements
Module: ramdisk_sequencer

Interface
REQ-001 The parameters SHALL be, one per line:
- BLOCKS, 120, number of blocks on the RAM disk.
- BLOCK_SIZE, 256, words per block.
- ACK_TIMEOUT, 8, cycles allowed for rd_command_ready to drop after a command is issued.
- BLK_TIMEOUT, 1024, cycles allowed for one block to complete.
REQ-002 The ports SHALL be, one per line:
- clk  in  1  single clock (20MHz).
- reset  in  1  synchronous, active-low; the sequencer is in reset while reset=0.
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
- op_write  in  1  1=write to disk, 0=read from disk; sampled with start.
- start_block  in  32  first block of the transfer.
- block_count  in  16  number of blocks to transfer.
- abort  in  1  requests the transfer stop at the next block boundary.
- busy  out  1  high from accepted start to done.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky fault flag; cleared by the next accepted start.
- aborted  out  1  sticky; the last transfer ended by abort; cleared by the next accepted start.
- blocks_left  out  16  blocks not yet completed.
- rd_command_ready  in  1  RAM disk is idle and ready for a command.
- rd_read_cmd  out  1  read command to the RAM disk.
- rd_write_cmd  out  1  write command to the RAM disk.
- rd_block_address  out  32  block address for the current command.
- wfifo_level  in  10  words held in the write FIFO.
- rfifo_free  in  10  free words in the read FIFO.

Function
REQ-003 States SHALL be IDLE, GATE, ISSUE, WAIT_ACK, WAIT_DONE, FINISH.
REQ-004 start=1 in IDLE SHALL latch op_write, start_block and block_count, set busy, clear error and aborted, and go to GATE.
REQ-005 If block_count=0, or start_block+block_count>BLOCKS (compared at 33 bits, no wrap), the transfer SHALL go IDLE->FINISH instead, with error=1 unless block_count=0.
REQ-006 GATE SHALL wait until the FIFO can hold a full block, then go to ISSUE:
- write: wfifo_level>=BLOCK_SIZE.
- read: rfifo_free>=BLOCK_SIZE.
- If abort=1 while in GATE, set aborted and go to FINISH.
REQ-007 In ISSUE, the command SHALL be driven from a register:
- rd_read_cmd or rd_write_cmd is asserted (never both), with rd_block_address equal to the current block.
- The state moves to WAIT_ACK.
- Earliest command assertion is 2 cycles after start is sampled.
REQ-008 In WAIT_ACK, the command SHALL stay asserted until rd_command_ready=0 is sampled. It SHALL then deassert on the next edge and the state moves to WAIT_DONE.
REQ-009 In WAIT_DONE, when rd_command_ready=1 is sampled, the sequencer SHALL:
- decrement blocks_left;
- increment the current block;
- go to FINISH if blocks_left reaches 0 or abort is pending, and to GATE otherwise.
REQ-010 An abort pulse seen in any non-IDLE state SHALL be held pending. A block already issued always completes, because the RAM disk has no cancel.
REQ-011 If the ACK_TIMEOUT or BLK_TIMEOUT counter expires, the sequencer SHALL set error, drop the command, and go to FINISH.
REQ-012 FINISH SHALL pulse done for exactly one cycle, clear busy on the same edge, and return to IDLE.
REQ-013 start while busy SHALL be ignored.
REQ-014 blocks_left SHALL show the latched count after start and hold its last value in IDLE.

Reset
REQ-015 While reset=0, the sequencer SHALL:
- go to IDLE;
- clear busy, done, error, aborted, rd_read_cmd, rd_write_cmd and the pending abort;
- set blocks_left and rd_block_address to 0.
REQ-016 A reset in the middle of a transfer SHALL drop the command within one cycle. The RAM disk's own reset is the top level's responsibility.

Structure
REQ-017 BLOCK_SIZE, the state encodings, and the RAM-disk command handshake constants SHALL live in the shared definitions file ramdisk_defs.
REQ-018 The timeout counter SHALL be one sub-module, xfer_watchdog, with load, limit and expired signals, used for both ACK_TIMEOUT and BLK_TIMEOUT.

Verification
REQ-019 The bench SHALL cover these directed scenarios, using a model of the RAM disk handshake:
- Write, start_block=2, count=3, wfifo_level=512: three write commands at addresses 2, 3, 4; done pulses once; blocks_left=0; error=0.
- Read, count=1, rfifo_free=100: no command until rfifo_free is raised to 256; the command follows within 2 cycles.
- start_block=118, count=3 with BLOCKS=120: no command issued; done and error both asserted within 2 cycles.
- Abort pulse during the second block of a count=5 read: that block completes; done follows; aborted=1; blocks_left=3.
- Model never drops rd_command_ready: error=1 after 8 cycles; command deasserted; done pulses.
- reset=0 mid-WAIT_DONE: next cycle all outputs are at their reset values; a later start runs normally.
